// File: rtl/udp_tx_pkg.sv
// udp_tx_pkg
//   Shared constants and the framer state type for the UDP transmit framer.
package udp_tx_pkg;

   localparam int UDP_HDR_BYTES = 8;

   typedef enum logic [1:0] {
      FILL = 2'd0,
      HDR  = 2'd1,
      SEND = 2'd2
   } state_t;

endpackage

// File: rtl/simple_dual_port_ram.sv
// simple_dual_port_ram
//   One write port, one read port with a registered (one-cycle) read.
//   Contents are not reset.
//   Ports: clk, i_we/i_waddr/i_wdata (write), i_raddr/o_rdata (read).
module simple_dual_port_ram #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 1024,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [AW-1:0]     i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [AW-1:0]     i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      o_rdata <= r_mem[i_raddr];
   end

endmodule

// File: rtl/udp_tx_framer.sv
// udp_tx_framer
//   Store-and-forward UDP datagram originator. Buffers one payload frame,
//   then emits a UDP header (length = payload + 8, addressing taken from the
//   cfg_* inputs at close time) followed by the buffered payload.
//   Ports:
//     clk, reset            single clock, synchronous active-high reset
//     s_t*                  payload input stream (tuser on tlast = bad frame)
//     cfg_*                 destination IP / source port / destination port
//     m_udp_hdr_*, m_udp_*  header handshake and fields
//     m_t*                  payload output stream
//
//   state | meaning
//   FILL  | accepting input beats into the buffer
//   HDR   | header presented, byte 0 prefetched from RAM
//   SEND  | streaming buffered payload out
module udp_tx_framer
   import udp_tx_pkg::*;
#(
   parameter int MAX_PAYLOAD = 1024,
   parameter int CNT_W       = $clog2(MAX_PAYLOAD) + 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  s_tdata,
   input  logic        s_tvalid,
   output logic        s_tready,
   input  logic        s_tlast,
   input  logic        s_tuser,
   input  logic [31:0] cfg_dest_ip,
   input  logic [15:0] cfg_source_port,
   input  logic [15:0] cfg_dest_port,
   output logic        m_udp_hdr_valid,
   input  logic        m_udp_hdr_ready,
   output logic [31:0] m_udp_ip_dest_ip,
   output logic [15:0] m_udp_source_port,
   output logic [15:0] m_udp_dest_port,
   output logic [15:0] m_udp_length,
   output logic [7:0]  m_tdata,
   output logic        m_tvalid,
   input  logic        m_tready,
   output logic        m_tlast,
   output logic        m_tuser
);

   localparam int AW = $clog2(MAX_PAYLOAD);

   state_t           r_state, w_state_next;
   logic [CNT_W-1:0] r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW-1:0]    r_last_idx;
   logic             r_hdr_valid;
   logic             r_tvalid;
   logic [31:0]      r_dest_ip;
   logic [15:0]      r_source_port;
   logic [15:0]      r_dest_port;
   logic [15:0]      r_length;

   logic             w_in_acc;
   logic [CNT_W-1:0] w_cnt_next;
   logic             w_close;
   logic             w_drop;
   logic             w_hdr_hs;
   logic             w_out_acc;
   logic             w_final;
   logic [AW-1:0]    w_rd_addr;
   logic [7:0]       w_ram_q;

   assign s_tready   = (r_state == FILL) && !reset;
   assign w_in_acc   = s_tvalid && s_tready;
   assign w_cnt_next = r_wr_ptr + 1'b1;
   assign w_close    = w_in_acc && (s_tlast || (w_cnt_next == CNT_W'(MAX_PAYLOAD)));
   assign w_drop     = w_close && s_tlast && s_tuser;
   assign w_hdr_hs   = r_hdr_valid && m_udp_hdr_ready;
   assign w_out_acc  = r_tvalid && m_tready;
   assign w_final    = w_out_acc && (r_rd_ptr == r_last_idx);

   // The RAM read address runs one step ahead of the displayed index so the
   // RAM output register always holds the byte currently on m_tdata. Outside
   // SEND the index sits at 0, which prefetches byte 0 during HDR.
   assign w_rd_addr  = ((r_state == SEND) && w_out_acc) ? r_rd_ptr + 1'b1 : r_rd_ptr;

   simple_dual_port_ram #(
      .DATA_W (8),
      .DEPTH  (MAX_PAYLOAD)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_in_acc),
      .i_waddr (r_wr_ptr[AW-1:0]),
      .i_wdata (s_tdata),
      .i_raddr (w_rd_addr),
      .o_rdata (w_ram_q)
   );

   always_ff @(posedge clk) begin
      if (reset) r_state <= FILL;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         FILL:    if (w_close && !w_drop) w_state_next = HDR;
         HDR:     if (w_hdr_hs)           w_state_next = SEND;
         SEND:    if (w_final)            w_state_next = FILL;
         default:                         w_state_next = FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_last_idx    <= '0;
         r_hdr_valid   <= 1'b0;
         r_tvalid      <= 1'b0;
         r_dest_ip     <= '0;
         r_source_port <= '0;
         r_dest_port   <= '0;
         r_length      <= '0;
      end else begin
         case (r_state)
            FILL: begin
               if (w_in_acc) begin
                  r_wr_ptr <= w_drop ? '0 : w_cnt_next;
                  if (w_close && !w_drop) begin
                     // Pre-increment pointer is the index of the last byte.
                     r_last_idx    <= AW'(r_wr_ptr);
                     r_length      <= 16'(w_cnt_next) + 16'(UDP_HDR_BYTES);
                     r_dest_ip     <= cfg_dest_ip;
                     r_source_port <= cfg_source_port;
                     r_dest_port   <= cfg_dest_port;
                     r_hdr_valid   <= 1'b1;
                  end
               end
            end
            HDR: begin
               if (w_hdr_hs) begin
                  r_hdr_valid <= 1'b0;
                  r_tvalid    <= 1'b1;
               end
            end
            SEND: begin
               if (w_out_acc) begin
                  r_rd_ptr <= r_rd_ptr + 1'b1;
                  if (w_final) begin
                     r_tvalid <= 1'b0;
                     r_rd_ptr <= '0;
                     r_wr_ptr <= '0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign m_udp_hdr_valid   = r_hdr_valid;
   assign m_udp_ip_dest_ip  = r_dest_ip;
   assign m_udp_source_port = r_source_port;
   assign m_udp_dest_port   = r_dest_port;
   assign m_udp_length      = r_length;
   assign m_tdata           = w_ram_q;
   assign m_tvalid          = r_tvalid;
   assign m_tlast           = r_tvalid && (r_rd_ptr == r_last_idx);
   assign m_tuser           = 1'b0;

endmodule

// File: tb/tb_udp_tx_framer.sv
module tb_udp_tx_framer;

   localparam int MAXP = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  s_tdata = '0;
   logic        s_tvalid = 1'b0;
   logic        s_tready;
   logic        s_tlast = 1'b0;
   logic        s_tuser = 1'b0;
   logic [31:0] cfg_dest_ip = 32'h0A00_0002;
   logic [15:0] cfg_source_port = 16'd5000;
   logic [15:0] cfg_dest_port = 16'd6000;
   logic        m_udp_hdr_valid;
   logic        m_udp_hdr_ready = 1'b1;
   logic [31:0] m_udp_ip_dest_ip;
   logic [15:0] m_udp_source_port;
   logic [15:0] m_udp_dest_port;
   logic [15:0] m_udp_length;
   logic [7:0]  m_tdata;
   logic        m_tvalid;
   logic        m_tready = 1'b1;
   logic        m_tlast;
   logic        m_tuser;

   always #5 clk = ~clk;

   udp_tx_framer #(.MAX_PAYLOAD(MAXP)) dut (
      .clk               (clk),
      .reset             (reset),
      .s_tdata           (s_tdata),
      .s_tvalid          (s_tvalid),
      .s_tready          (s_tready),
      .s_tlast           (s_tlast),
      .s_tuser           (s_tuser),
      .cfg_dest_ip       (cfg_dest_ip),
      .cfg_source_port   (cfg_source_port),
      .cfg_dest_port     (cfg_dest_port),
      .m_udp_hdr_valid   (m_udp_hdr_valid),
      .m_udp_hdr_ready   (m_udp_hdr_ready),
      .m_udp_ip_dest_ip  (m_udp_ip_dest_ip),
      .m_udp_source_port (m_udp_source_port),
      .m_udp_dest_port   (m_udp_dest_port),
      .m_udp_length      (m_udp_length),
      .m_tdata           (m_tdata),
      .m_tvalid          (m_tvalid),
      .m_tready          (m_tready),
      .m_tlast           (m_tlast),
      .m_tuser           (m_tuser)
   );

   typedef struct {
      logic [31:0] ip;
      logic [15:0] sp;
      logic [15:0] dp;
      logic [15:0] len;
   } hdr_t;

   typedef struct {
      logic [7:0] d;
      logic       l;
   } beat_t;

   hdr_t  hdr_q[$];
   beat_t beat_q[$];
   int    n_cmp = 0;
   int    n_err = 0;
   int    beats_seen = 0;
   bit    bp_en = 1'b0;
   bit    hold_hdr = 1'b0;
   bit    gaps_en = 1'b0;

   logic        prev_t_stall = 1'b0;
   logic        prev_h_stall = 1'b0;
   logic [7:0]  prev_d;
   logic        prev_l;
   logic [15:0] prev_len;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   // Monitor: new ready values are chosen first, then whatever handshake will
   // happen at the next rising edge is checked against the scoreboard.
   always @(negedge clk) begin
      hdr_t  h;
      beat_t b;
      m_udp_hdr_ready = hold_hdr ? 1'b0 : (bp_en ? 1'($urandom_range(0, 1)) : 1'b1);
      m_tready        = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (reset) begin
         prev_t_stall = 1'b0;
         prev_h_stall = 1'b0;
      end else begin
         if (prev_h_stall) begin
            check("hdr_valid_held", m_udp_hdr_valid, 1);
            check("hdr_len_held", m_udp_length, prev_len);
         end
         if (prev_t_stall) begin
            check("tvalid_held", m_tvalid, 1);
            check("tdata_held", m_tdata, prev_d);
            check("tlast_held", m_tlast, prev_l);
         end
         if (m_udp_hdr_valid && m_udp_hdr_ready) begin
            if (hdr_q.size() == 0) fail_now("unexpected_header");
            else begin
               h = hdr_q.pop_front();
               check("hdr_ip", m_udp_ip_dest_ip, h.ip);
               check("hdr_sport", m_udp_source_port, h.sp);
               check("hdr_dport", m_udp_dest_port, h.dp);
               check("hdr_len", m_udp_length, h.len);
            end
         end
         if (m_tvalid && m_tready) begin
            beats_seen++;
            if (beat_q.size() == 0) fail_now("unexpected_beat");
            else begin
               b = beat_q.pop_front();
               check("tdata", m_tdata, b.d);
               check("tlast", m_tlast, b.l);
               check("tuser", m_tuser, 0);
            end
         end
         prev_h_stall = m_udp_hdr_valid && !m_udp_hdr_ready;
         prev_t_stall = m_tvalid && !m_tready;
         prev_d       = m_tdata;
         prev_l       = m_tlast;
         prev_len     = m_udp_length;
      end
   end

   // Reference: a frame splits into datagrams of at most MAXP bytes; a bad
   // frame loses only its final (tlast-closed) piece.
   task automatic send_frame(input int n, input bit bad, input bit rnd, input logic [7:0] first);
      logic [7:0] bytes[$];
      int nch, lo, hi, guard;
      hdr_t  h;
      beat_t b;
      for (int i = 0; i < n; i++) bytes.push_back(rnd ? 8'($urandom) : 8'(first + 8'(i)));
      nch = (n + MAXP - 1) / MAXP;
      for (int c = 0; c < nch; c++) begin
         lo = c * MAXP;
         hi = (lo + MAXP < n) ? lo + MAXP : n;
         if (!(bad && c == nch - 1)) begin
            h.ip = cfg_dest_ip;
            h.sp = cfg_source_port;
            h.dp = cfg_dest_port;
            h.len = 16'(hi - lo + 8);
            hdr_q.push_back(h);
            for (int j = lo; j < hi; j++) begin
               b.d = bytes[j];
               b.l = (j == hi - 1);
               beat_q.push_back(b);
            end
         end
      end
      for (int i = 0; i < n; i++) begin
         if (gaps_en && $urandom_range(0, 3) == 0) begin
            @(negedge clk);
            s_tvalid = 1'b0;
            @(posedge clk);
         end
         @(negedge clk);
         s_tvalid = 1'b1;
         s_tdata  = bytes[i];
         s_tlast  = (i == n - 1);
         s_tuser  = bad && (i == n - 1);
         guard = 0;
         while (!s_tready && guard < 3000) begin
            @(negedge clk);
            guard++;
         end
         if (!s_tready) begin
            fail_now("input_accept_timeout");
            s_tvalid = 1'b0;
            return;
         end
         @(posedge clk);
      end
      #1;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      s_tuser  = 1'b0;
   endtask

   task automatic wait_idle();
      int guard = 0;
      while ((hdr_q.size() != 0 || beat_q.size() != 0) && guard < 8000) begin
         @(posedge clk);
         guard++;
      end
      if (hdr_q.size() != 0 || beat_q.size() != 0) fail_now("drain_timeout");
      repeat (3) @(posedge clk);
   endtask

   initial begin
      #900_000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int base;
      bit hit;

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_s_tready", s_tready, 0);
      check("rst_hdr_valid", m_udp_hdr_valid, 0);
      check("rst_tvalid", m_tvalid, 0);
      check("rst_tlast", m_tlast, 0);
      check("rst_tuser", m_tuser, 0);
      check("rst_len", m_udp_length, 0);
      check("rst_ip", m_udp_ip_dest_ip, 0);
      check("rst_sport", m_udp_source_port, 0);
      check("rst_dport", m_udp_dest_port, 0);
      reset = 1'b0;
      @(negedge clk);
      check("s_tready_after_rst", s_tready, 1);

      // 4-byte frame, unthrottled, with latency checks
      send_frame(4, 0, 0, 8'h01);
      @(negedge clk);
      check("hdr_valid_latency", m_udp_hdr_valid, 1);
      check("s_tready_in_hdr", s_tready, 0);
      @(negedge clk);
      check("tvalid_latency", m_tvalid, 1);
      wait_idle();

      // Bad 10-byte frame, then good AA BB
      send_frame(10, 1, 1, 8'h00);
      send_frame(2, 0, 0, 8'hAA);
      wait_idle();

      // 20-byte frame with 16-byte buffer: forced close then tlast close
      send_frame(20, 0, 0, 8'h30);
      wait_idle();

      // cfg change while the header is held
      hold_hdr = 1'b1;
      cfg_dest_port = 16'd6000;
      send_frame(5, 0, 1, 8'h00);
      repeat (2) @(negedge clk);
      check("hdr_waiting", m_udp_hdr_valid, 1);
      cfg_dest_port = 16'd7000;
      repeat (3) @(negedge clk);
      hold_hdr = 1'b0;
      wait_idle();
      send_frame(3, 0, 1, 8'h00);
      wait_idle();

      // Reset in SEND after 3 of 8 bytes
      base = beats_seen;
      send_frame(8, 0, 1, 8'h00);
      hit = 1'b0;
      for (int k = 0; k < 200 && !hit; k++) begin
         @(posedge clk);
         if (beats_seen >= base + 3) hit = 1'b1;
      end
      if (!hit) fail_now("reset_test_wait");
      #1;
      reset = 1'b1;
      beat_q.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("tvalid_after_mid_rst", m_tvalid, 0);
      check("hdr_valid_after_mid_rst", m_udp_hdr_valid, 0);
      check("beats_before_rst", beats_seen - base, 3);
      send_frame(1, 0, 0, 8'h5A);
      wait_idle();

      // Random traffic with backpressure
      bp_en = 1'b1;
      gaps_en = 1'b1;
      for (int f = 0; f < 100; f++) begin
         cfg_dest_ip     = $urandom;
         cfg_source_port = 16'($urandom);
         cfg_dest_port   = 16'($urandom);
         send_frame($urandom_range(1, 40), ($urandom_range(0, 4) == 0), 1, 8'h00);
      end
      wait_idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
